// File: rtl/dram_if.sv
// CPU request signals in, DRAM strobes/address and acknowledge out, for dram_controller.
interface dram_if;
  logic        CS_DRAM_n;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        RW;
  logic [20:1] ADDR;
  logic [9:0]  DRAM_ADDR;
  logic        RAS_n;
  logic        CASU_n;
  logic        CASL_n;
  logic        WE_n;
  logic        DTACK_DRAM_n;
  logic        REF_BUSY;

  modport master (
    output CS_DRAM_n, AS_n, UDS_n, LDS_n, RW, ADDR,
    input  DRAM_ADDR, RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n, REF_BUSY
  );

  modport slave (
    input  CS_DRAM_n, AS_n, UDS_n, LDS_n, RW, ADDR,
    output DRAM_ADDR, RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n, REF_BUSY
  );
endinterface

// File: rtl/dram_controller.sv
// FPM DRAM sequencer for CPU cycles and CAS-before-RAS refresh; RAS one edge after request, CAS+DTACK RCD_CYCLES later.
// Defining DRAM_EXTRA_WAIT_EN inserts one DTACK wait state (COL_WAIT) after CAS; CPU stalls on DTACK, refresh waits for PRE.
module dram_controller #(
  parameter int REFRESH_PERIOD = 312,
  parameter int RCD_CYCLES     = 1,
  parameter int RAS_REF_CYCLES = 3,
  parameter int RP_CYCLES      = 2
) (
  input logic   CLK,
  input logic   RST,
  dram_if.slave io_dram
);
  localparam int TW    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int MAXH1 = (RCD_CYCLES > RAS_REF_CYCLES) ? RCD_CYCLES : RAS_REF_CYCLES;
  localparam int MAXH  = (MAXH1 > RP_CYCLES) ? MAXH1 : RP_CYCLES;
  localparam int CW    = $clog2(MAXH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_COL_WAIT, S_HOLD, S_REF_CAS, S_REF_RAS, S_PRE
  } state_t;

`ifdef DRAM_EXTRA_WAIT_EN
  localparam state_t S_CAS_HIT = S_COL_WAIT;
`else
  localparam state_t S_CAS_HIT = S_HOLD;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic          r_pending;
  logic [CW-1:0] r_cnt;

  logic [9:0] r_dram_addr;
  logic       r_ras_n, r_casu_n, r_casl_n, r_we_n, r_dtack_n, r_ref_busy;
  logic [9:0] w_addr_nxt;
  logic       w_ras_n_nxt, w_casu_n_nxt, w_casl_n_nxt, w_we_n_nxt, w_dtack_n_nxt, w_busy_nxt;

  logic       w_wrap, w_ref_req, w_cpu_req, w_ds, w_abort;
  logic       w_row_done, w_ras_done, w_pre_done;
  logic [9:0] w_row, w_col;

  assign w_row      = io_dram.ADDR[20:11];
  assign w_col      = io_dram.ADDR[10:1];
  assign w_wrap     = (r_timer == TW'(REFRESH_PERIOD - 1));
  // A wrap on the same edge as a CPU request must already win arbitration.
  assign w_ref_req  = r_pending | w_wrap;
  assign w_cpu_req  = ~io_dram.CS_DRAM_n & ~io_dram.AS_n;
  assign w_ds       = ~io_dram.UDS_n | ~io_dram.LDS_n;
  assign w_abort    = io_dram.AS_n;
  assign w_row_done = (r_cnt == CW'(RCD_CYCLES - 1));
  assign w_ras_done = (r_cnt == CW'(RAS_REF_CYCLES - 1));
  assign w_pre_done = (r_cnt == CW'(RP_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_wrap ? '0 : r_timer + TW'(1);
      if (w_state_nxt == S_REF_CAS) begin
        r_pending <= 1'b0;
      end else if (w_wrap) begin
        r_pending <= 1'b1;
      end
      r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ref_req) begin
          w_state_nxt = S_REF_CAS;
        end else if (w_cpu_req) begin
          w_state_nxt = S_ROW;
        end
      end
      // Strobes already low when tRCD expires skip straight past the COL wait.
      S_ROW: begin
        if (w_abort) begin
          w_state_nxt = S_PRE;
        end else if (w_row_done) begin
          w_state_nxt = w_ds ? S_CAS_HIT : S_COL;
        end
      end
      S_COL: begin
        if (w_abort) begin
          w_state_nxt = S_PRE;
        end else if (w_ds) begin
          w_state_nxt = S_CAS_HIT;
        end
      end
      S_COL_WAIT: w_state_nxt = w_abort ? S_PRE : S_HOLD;
      S_HOLD:     w_state_nxt = w_abort ? S_PRE : S_HOLD;
      S_REF_CAS:  w_state_nxt = S_REF_RAS;
      S_REF_RAS:  w_state_nxt = w_ras_done ? S_PRE : S_REF_RAS;
      S_PRE:      w_state_nxt = w_pre_done ? S_IDLE : S_PRE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr_nxt    = w_row;
    w_ras_n_nxt   = 1'b1;
    w_casu_n_nxt  = 1'b1;
    w_casl_n_nxt  = 1'b1;
    w_we_n_nxt    = 1'b1;
    w_dtack_n_nxt = 1'b1;
    w_busy_nxt    = r_ref_busy;
    case (w_state_nxt)
      S_IDLE: w_busy_nxt = 1'b0;
      S_ROW: begin
        w_ras_n_nxt = 1'b0;
        w_we_n_nxt  = (r_state == S_IDLE) ? io_dram.RW : r_we_n;
      end
      S_COL: begin
        w_ras_n_nxt = 1'b0;
        w_we_n_nxt  = r_we_n;
        w_addr_nxt  = w_col;
      end
      S_COL_WAIT, S_HOLD: begin
        w_ras_n_nxt   = 1'b0;
        w_we_n_nxt    = r_we_n;
        w_addr_nxt    = w_col;
        w_dtack_n_nxt = (w_state_nxt != S_HOLD);
        if (r_state == S_ROW || r_state == S_COL) begin
          w_casu_n_nxt = io_dram.UDS_n;
          w_casl_n_nxt = io_dram.LDS_n;
        end else begin
          w_casu_n_nxt = r_casu_n;
          w_casl_n_nxt = r_casl_n;
        end
      end
      S_REF_CAS: begin
        w_casu_n_nxt = 1'b0;
        w_casl_n_nxt = 1'b0;
        w_busy_nxt   = 1'b1;
      end
      S_REF_RAS: begin
        w_ras_n_nxt  = 1'b0;
        w_casu_n_nxt = 1'b0;
        w_casl_n_nxt = 1'b0;
        w_busy_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dram_addr <= w_row;
      r_ras_n     <= 1'b1;
      r_casu_n    <= 1'b1;
      r_casl_n    <= 1'b1;
      r_we_n      <= 1'b1;
      r_dtack_n   <= 1'b1;
      r_ref_busy  <= 1'b0;
    end else begin
      r_dram_addr <= w_addr_nxt;
      r_ras_n     <= w_ras_n_nxt;
      r_casu_n    <= w_casu_n_nxt;
      r_casl_n    <= w_casl_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_dtack_n   <= w_dtack_n_nxt;
      r_ref_busy  <= w_busy_nxt;
    end
  end

  assign io_dram.DRAM_ADDR    = r_dram_addr;
  assign io_dram.RAS_n        = r_ras_n;
  assign io_dram.CASU_n       = r_casu_n;
  assign io_dram.CASL_n       = r_casl_n;
  assign io_dram.WE_n         = r_we_n;
  assign io_dram.DTACK_DRAM_n = r_dtack_n;
  assign io_dram.REF_BUSY     = r_ref_busy;
endmodule
